// File: rtl/ra_chk_pkg.sv
// Shared types and sizes for the array read-check engine.
// The array is 64 words of 72 bits, read through two ports.
package ra_chk_pkg;

  localparam int ADR_W = 6;
  localparam int DAT_W = 72;
  localparam int WORDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_SOLID,
    MODE_CHECKER,
    MODE_ADR,
    MODE_NADR
  } mode_e;

endpackage

// File: rtl/ra_chk_exp.sv
// Combinational expected-data generator: maps pattern mode, seed and word
// address to the 72-bit word the array should hold.
module ra_chk_exp
  import ra_chk_pkg::*;
(
  input  mode_e              mode,
  input  logic [DAT_W-1:0]   seed,
  input  logic [ADR_W-1:0]   adr,
  output logic [DAT_W-1:0]   dat
);

  logic [ADR_W-1:0] adr_rev;
  logic [DAT_W-1:0] adr_word;

  // Address patterns place the address MSB at bit 0 of every 6-bit group.
  always_comb begin
    adr_rev  = '0;
    for (int i = 0; i < ADR_W; i++) begin
      adr_rev[i] = adr[ADR_W-1-i];
    end
    adr_word = {(DAT_W/ADR_W){adr_rev}};
    dat      = seed;
    case (mode)
      MODE_SOLID:   dat = seed;
      MODE_CHECKER: dat = adr[0] ? ~seed : seed;
      MODE_ADR:     dat = adr_word;
      MODE_NADR:    dat = ~adr_word;
      default:      dat = seed;
    endcase
  end

endmodule

// File: rtl/ra_rd_chk_sdr.sv
// Two-port array read-check sweep: issues paired reads over a wrapping
// address range, compares returned data after RD_LAT cycles, logs failures.
module ra_rd_chk_sdr
  import ra_chk_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DAT_W-1:0]  seed,
  input  logic [ADR_W-1:0]  start_adr,
  input  logic [ADR_W-1:0]  end_adr,
  output logic              rd0_enb,
  output logic              rd1_enb,
  output logic [ADR_W-1:0]  rd0_adr,
  output logic [ADR_W-1:0]  rd1_adr,
  input  logic [DAT_W-1:0]  rd0_dat,
  input  logic [DAT_W-1:0]  rd1_dat,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [FCNT_W-1:0] fail_cnt,
  output logic [ADR_W-1:0]  fail_adr,
  output logic              fail_port
);

  localparam logic [1:0] DRAIN_INIT = 2'(RD_LAT - 1);

  state_e            state, state_d;
  mode_e             mode_q;
  logic [DAT_W-1:0]  seed_q;
  logic [ADR_W-1:0]  ptr;
  logic [ADR_W-1:0]  remain;
  logic [1:0]        drain_cnt;
  logic [ADR_W-1:0]  span;
  logic              start_ok;
  logic              issue_more;

  logic              v0_pipe [RD_LAT];
  logic              v1_pipe [RD_LAT];
  logic [ADR_W-1:0]  a0_pipe [RD_LAT];
  logic [ADR_W-1:0]  a1_pipe [RD_LAT];
  logic [DAT_W-1:0]  exp0, exp1;
  logic              miss0, miss1;
  logic [FCNT_W:0]   cnt_sum;

  assign span = end_adr - start_adr;
  assign busy = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    start_ok   = 1'b0;
    issue_more = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort || remain == '0) state_d = ST_DRAIN;
        else                        issue_more = 1'b1;
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // remain counts words still to issue beyond those already on the ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= MODE_SOLID;
      seed_q    <= '0;
      ptr       <= '0;
      remain    <= '0;
      drain_cnt <= '0;
      rd0_enb   <= 1'b0;
      rd1_enb   <= 1'b0;
      rd0_adr   <= '0;
      rd1_adr   <= '0;
    end else begin
      if (start_ok) begin
        mode_q  <= mode_e'(mode);
        seed_q  <= seed;
        rd0_enb <= 1'b1;
        rd0_adr <= start_adr;
        rd1_enb <= (span != '0);
        rd1_adr <= start_adr + 6'd1;
        ptr     <= start_adr + 6'd2;
        remain  <= (span == '0) ? '0 : span - 6'd1;
      end else if (issue_more) begin
        rd0_enb <= 1'b1;
        rd0_adr <= ptr;
        rd1_enb <= (remain != 6'd1);
        rd1_adr <= ptr + 6'd1;
        ptr     <= ptr + 6'd2;
        remain  <= (remain == 6'd1) ? '0 : remain - 6'd2;
      end else begin
        rd0_enb <= 1'b0;
        rd1_enb <= 1'b0;
      end
      if (state == ST_ISSUE && state_d == ST_DRAIN) drain_cnt <= DRAIN_INIT;
      else if (state == ST_DRAIN)                   drain_cnt <= drain_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        v0_pipe[i] <= 1'b0;
        v1_pipe[i] <= 1'b0;
        a0_pipe[i] <= '0;
        a1_pipe[i] <= '0;
      end
    end else begin
      v0_pipe[0] <= rd0_enb;
      v1_pipe[0] <= rd1_enb;
      a0_pipe[0] <= rd0_adr;
      a1_pipe[0] <= rd1_adr;
      for (int i = 1; i < RD_LAT; i++) begin
        v0_pipe[i] <= v0_pipe[i-1];
        v1_pipe[i] <= v1_pipe[i-1];
        a0_pipe[i] <= a0_pipe[i-1];
        a1_pipe[i] <= a1_pipe[i-1];
      end
    end
  end

  ra_chk_exp u_exp0 (
    .mode (mode_q),
    .seed (seed_q),
    .adr  (a0_pipe[RD_LAT-1]),
    .dat  (exp0)
  );

  ra_chk_exp u_exp1 (
    .mode (mode_q),
    .seed (seed_q),
    .adr  (a1_pipe[RD_LAT-1]),
    .dat  (exp1)
  );

  always_comb begin
    miss0   = v0_pipe[RD_LAT-1] && (rd0_dat != exp0);
    miss1   = v1_pipe[RD_LAT-1] && (rd1_dat != exp1);
    cnt_sum = {1'b0, fail_cnt} + (FCNT_W+1)'(miss0) + (FCNT_W+1)'(miss1);
  end

  // Port 0 holds the lower address of a pair, so it wins a same-cycle tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail      <= 1'b0;
      fail_cnt  <= '0;
      fail_adr  <= '0;
      fail_port <= 1'b0;
    end else if (start_ok) begin
      fail      <= 1'b0;
      fail_cnt  <= '0;
      fail_adr  <= '0;
      fail_port <= 1'b0;
    end else if (miss0 || miss1) begin
      fail     <= 1'b1;
      fail_cnt <= cnt_sum[FCNT_W] ? '1 : cnt_sum[FCNT_W-1:0];
      if (!fail) begin
        fail_adr  <= miss0 ? a0_pipe[RD_LAT-1] : a1_pipe[RD_LAT-1];
        fail_port <= !miss0;
      end
    end
  end

endmodule

// File: tb/tb_ra_rd_chk_sdr.sv
// Directed bench for ra_rd_chk_sdr: table of sweeps against a behavioural
// two-port array, plus hand sequences for wrap, abort and mid-sweep reset.
module tb_ra_rd_chk_sdr;

  localparam int RD_LAT = 2;
  localparam int FCNT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [71:0]       seed;
  logic [5:0]        start_adr, end_adr;
  logic              rd0_enb, rd1_enb;
  logic [5:0]        rd0_adr, rd1_adr;
  logic [71:0]       rd0_dat, rd1_dat;
  logic              busy, done, fail;
  logic [FCNT_W-1:0] fail_cnt;
  logic [5:0]        fail_adr;
  logic              fail_port;

  int checks = 0;
  int errors = 0;

  logic [71:0] mem [64];
  logic [71:0] p0 [RD_LAT];
  logic [71:0] p1 [RD_LAT];

  typedef struct {
    logic [1:0]  mode;
    logic [71:0] seed;
    logic [5:0]  sa;
    logic [5:0]  ea;
    logic [63:0] bad;
    int          cyc;
    int          n0;
    int          n1;
    int          efail;
    int          ecnt;
    int          eadr;
    int          eport;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  ra_rd_chk_sdr #(.RD_LAT(RD_LAT), .FCNT_W(FCNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .seed      (seed),
    .start_adr (start_adr),
    .end_adr   (end_adr),
    .rd0_enb   (rd0_enb),
    .rd1_enb   (rd1_enb),
    .rd0_adr   (rd0_adr),
    .rd1_adr   (rd1_adr),
    .rd0_dat   (rd0_dat),
    .rd1_dat   (rd1_dat),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_cnt  (fail_cnt),
    .fail_adr  (fail_adr),
    .fail_port (fail_port)
  );

  // Behavioural array: data appears RD_LAT cycles after the address cycle.
  always @(posedge clk) begin
    p0[0] <= mem[rd0_adr];
    p1[0] <= mem[rd1_adr];
    for (int i = 1; i < RD_LAT; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign rd0_dat = p0[RD_LAT-1];
  assign rd1_dat = p1[RD_LAT-1];

  function automatic logic [71:0] pattern(input logic [1:0] m, input logic [71:0] s,
                                          input logic [5:0] a);
    logic [71:0] w;
    w = '0;
    for (int b = 0; b < 72; b++) w[b] = a[5 - (b % 6)];
    case (m)
      2'd0:    return s;
      2'd1:    return (a % 2 == 1) ? ~s : s;
      2'd2:    return w;
      default: return ~w;
    endcase
  endfunction

  task automatic preload(input logic [1:0] m, input logic [71:0] s, input logic [63:0] bad);
    for (int a = 0; a < 64; a++) begin
      mem[a] = pattern(m, s, 6'(a));
      if (bad[a]) mem[a] = mem[a] ^ {1'b1, 71'b0};
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one sweep and counts cycles from the start edge until done.
  task automatic applyStimulus(input vec_t v, output int cyc, output int n0, output int n1);
    preload(v.mode, v.seed, v.bad);
    @(negedge clk);
    mode = v.mode; seed = v.seed; start_adr = v.sa; end_adr = v.ea; start = 1'b1;
    cyc = 0; n0 = 0; n1 = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (rd0_enb) n0++;
      if (rd1_enb) n1++;
      if (done) break;
    end
  endtask

  int cyc, n0, n1;

  initial begin
    vecs[0] = '{2'd2, 72'h0, 6'd0, 6'd63, 64'h0, 35, 32, 32, 0, 0, 0, 0};
    vecs[1] = '{2'd0, {9{8'hA5}}, 6'd0, 6'd63, 64'h20, 35, 32, 32, 1, 1, 5, 1};
    vecs[2] = '{2'd1, 72'h01_2345_6789_ABCD_EF5A, 6'd62, 6'd2, 64'h0, 6, 3, 2, 0, 0, 0, 0};
    vecs[3] = '{2'd3, 72'h0, 6'd10, 6'd10, 64'h400, 4, 1, 0, 1, 1, 10, 0};
    vecs[4] = '{2'd2, 72'h0, 6'd7, 6'd6, {64{1'b1}}, 35, 32, 32, 1, 15, 7, 0};
    vecs[5] = '{2'd1, {9{8'h3C}}, 6'd3, 6'd8, 64'h140, 6, 3, 3, 1, 2, 6, 1};
    vecs[6] = '{2'd0, {9{8'hF0}}, 6'd20, 6'd25, 64'h30_0000, 6, 3, 3, 1, 2, 20, 0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; seed = '0;
    start_adr = '0; end_adr = '0;
    preload(2'd0, 72'h0, 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_outputs",
                int'({rd0_enb, rd1_enb, rd0_adr, rd1_adr, busy, done, fail, fail_cnt,
                      fail_adr, fail_port}), 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], cyc, n0, n1);
      $display("[TB] vector %0d swept %0d..%0d mode %0d", i, vecs[i].sa, vecs[i].ea, vecs[i].mode);
      checkOutput($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      checkOutput($sformatf("v%0d_rd0_issues", i), n0, vecs[i].n0);
      checkOutput($sformatf("v%0d_rd1_issues", i), n1, vecs[i].n1);
      checkOutput($sformatf("v%0d_fail", i), int'(fail), vecs[i].efail);
      checkOutput($sformatf("v%0d_fail_cnt", i), int'(fail_cnt), vecs[i].ecnt);
      checkOutput($sformatf("v%0d_fail_adr", i), int'(fail_adr), vecs[i].eadr);
      checkOutput($sformatf("v%0d_fail_port", i), int'(fail_port), vecs[i].eport);
    end

    // Wrapping range 62..2: pairs (62,63), (0,1), then 2 alone.
    preload(2'd0, 72'h0, 64'h0);
    @(negedge clk);
    mode = 2'd0; seed = 72'h0; start_adr = 6'd62; end_adr = 6'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checkOutput("wrap_issue1", int'({rd0_enb, rd0_adr, rd1_enb, rd1_adr}), int'({1'b1, 6'd62, 1'b1, 6'd63}));
    @(posedge clk); #1;
    checkOutput("wrap_issue2", int'({rd0_enb, rd0_adr, rd1_enb, rd1_adr}), int'({1'b1, 6'd0, 1'b1, 6'd1}));
    @(posedge clk); #1;
    checkOutput("wrap_issue3", int'({rd0_enb, rd0_adr, rd1_enb}), int'({1'b1, 6'd2, 1'b0}));
    @(posedge clk); #1;
    checkOutput("wrap_drain", int'({rd0_enb, rd1_enb, busy, rd0_adr}), int'({1'b0, 1'b0, 1'b1, 6'd2}));
    for (int k = 0; k < 10 && !done; k++) @(posedge clk);
    #1;
    checkOutput("wrap_done", int'(done), 1);

    // Abort during the second issue cycle; start with abort held still wins.
    preload(2'd2, 72'h0, 64'h0);
    @(negedge clk);
    mode = 2'd2; start_adr = 6'd0; end_adr = 6'd63; start = 1'b1; abort = 1'b1;
    cyc = 0; n0 = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      abort = (cyc == 2);
      if (rd0_enb) n0++;
      if (done) break;
    end
    abort = 1'b0;
    checkOutput("abort_cycles", cyc, 5);
    checkOutput("abort_issues", n0, 2);
    checkOutput("abort_fail", int'(fail), 0);

    // Reset in the middle of a failing sweep clears everything immediately.
    preload(2'd2, 72'h0, {64{1'b1}});
    @(negedge clk);
    mode = 2'd2; start_adr = 6'd0; end_adr = 6'd63; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("pre_reset_fail", int'(fail), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_outputs",
                int'({rd0_enb, rd1_enb, rd0_adr, rd1_adr, busy, done, fail, fail_cnt,
                      fail_adr, fail_port}), 0);
    @(negedge clk); reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("post_reset_fail", int'({fail, fail_cnt}), 0);
    checkOutput("post_reset_idle", int'({busy, done, rd0_enb}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
